// File: rtl/ctrl_burst_gen.sv
// Programmable pulse-burst generator driven by a firmware control register.
// A rising edge on start launches burst_len fixed-width pulses on pulse_out,
// separated by LowCycles-long gaps; busy/done/pulses_left feed a status register.
module ctrl_burst_gen #(
  parameter int HighCycles = 4,
  parameter int LowCycles  = 4,
  parameter int CountWidth = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CountWidth-1:0] burst_len,
  output logic                  pulse_out,
  output logic                  busy,
  output logic                  done,
  output logic [CountWidth-1:0] pulses_left
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    DONE
  } state_t;

  localparam logic [7:0] HighReload = 8'(HighCycles - 1);
  localparam logic [7:0] LowReload  = 8'(LowCycles - 1);

  state_t                state;
  state_t                state_next;
  logic [7:0]            timer;
  logic [7:0]            timer_next;
  logic                  start_d;
  logic                  start_edge;
  logic [CountWidth-1:0] left_next;
  logic                  pulse_next;
  logic                  busy_next;
  logic                  done_next;

  assign start_edge = start & ~start_d;

  // State, phase timer, start history and all outputs live in flops so that
  // pulse_out comes straight from a register and cannot glitch.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= 8'd0;
      start_d     <= 1'b0;
      pulse_out   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulses_left <= '0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      start_d     <= start;
      pulse_out   <= pulse_next;
      busy        <= busy_next;
      done        <= done_next;
      pulses_left <= left_next;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they line up
  // with the state register instead of lagging it by a cycle.
  always_comb begin
    state_next = state;
    timer_next = timer;
    left_next  = pulses_left;
    unique case (state)
      IDLE: begin
        if (start_edge && !abort) begin
          left_next = burst_len;
          if (burst_len == '0) begin
            state_next = DONE;
          end else begin
            state_next = HIGH;
            timer_next = HighReload;
          end
        end
      end
      HIGH: begin
        if (abort) begin
          state_next = IDLE;
          timer_next = 8'd0;
          left_next  = '0;
        end else if (timer == 8'd0) begin
          left_next = pulses_left - CountWidth'(1);
          if (left_next == '0) begin
            state_next = DONE;
          end else begin
            state_next = LOW;
            timer_next = LowReload;
          end
        end else begin
          timer_next = timer - 8'd1;
        end
      end
      LOW: begin
        if (abort) begin
          state_next = IDLE;
          timer_next = 8'd0;
          left_next  = '0;
        end else if (timer == 8'd0) begin
          state_next = HIGH;
          timer_next = HighReload;
        end else begin
          timer_next = timer - 8'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
    endcase
    pulse_next = (state_next == HIGH);
    busy_next  = (state_next == HIGH) || (state_next == LOW);
    done_next  = (state_next == DONE);
  end

endmodule

// File: doc/ctrl_burst_gen.md
# ctrl_burst_gen

Programmable pulse-burst generator that consumes bits of a `CyControlReg` instance. Firmware writes a burst length and a start bit through the control register. The block emits that many fixed-width pulses on `pulse_out` and reports `busy`, `done` and `pulses_left` for a status register. It decouples firmware writes from timing-critical pulse generation in UDB logic.

## Interface
Parameters:
- `HighCycles`, default 4: pulse high time in clocks. Legal range 1..255.
- `LowCycles`, default 4: gap between pulses in clocks. Legal range 1..255.
- `CountWidth`, default 4: width of `burst_len` and `pulses_left`. Legal range 1..8.

Ports:
- `clock`, in, 1: single clock. All logic is on its rising edge.
- `reset`, in, 1: synchronous, active-low.
- `start`, in, 1: control-register bit. A burst is requested on a rising edge of this bit. Direct, sync or pulse mode are all legal.
- `abort`, in, 1: level, active-high. Cancels a running burst.
- `burst_len`, in, `CountWidth`: number of pulses. Sampled only when a start is accepted.
- `pulse_out`, out, 1: burst output. Registered.
- `busy`, out, 1: high while in HIGH or LOW state. Registered.
- `done`, out, 1: one-cycle completion strobe. Registered.
- `pulses_left`, out, `CountWidth`: pulses remaining, including the current one. Registered.

## Operation
- **Start detection:** `start_d` flop. Start edge = `start & ~start_d`. Holding `start` high yields exactly one edge.
- **States:** IDLE, HIGH, LOW, DONE. A phase timer of 8 bits counts down and reloads on each phase entry.
- **IDLE:**
  - Start edge, `abort`=0, `burst_len`≠0: latch `pulses_left`=`burst_len`, load timer=`HighCycles`-1, go to HIGH.
  - Start edge, `burst_len`=0: go to DONE (no pulses).
  - `abort` high overrides a start edge; stay in IDLE.
- **HIGH:** `pulse_out`=1, `busy`=1. When timer=0: decrement `pulses_left`.
  - If the new value is 0, go to DONE.
  - Otherwise load timer=`LowCycles`-1 and go to LOW.
- **LOW:** `pulse_out`=0, `busy`=1. When timer=0: load timer=`HighCycles`-1 and go to HIGH.
- **DONE:** `done`=1 for exactly one cycle, then IDLE unconditionally. A start edge in DONE is ignored.
- **Trailing gap:** no LOW phase follows the last pulse.
- **Start while busy:** start edges in HIGH, LOW or DONE are ignored. There is no retrigger or queueing. `start_d` keeps tracking, so a level held through the burst does not restart it.
- **Abort:** `abort`=1 sampled in HIGH or LOW causes, at the same edge:
  - state goes to IDLE;
  - `pulse_out`=0, `busy`=0, `pulses_left`=0;
  - no `done` strobe.
- **`burst_len` changes** during a burst have no effect.
- **Reset:** `reset`=0 sampled at an edge forces state IDLE, timer 0, `start_d`=0 and all outputs 0. This applies mid-burst as well, and it truncates the current pulse.

## Timing
- **Convention:** "cycle N" means register values right after edge N. An input "at N" means sampled by edge N.
- **Start latency:** a start edge at N gives `pulse_out`=1 and `busy`=1 in cycle N. There is zero extra latency beyond registering.
- **Burst length:** a burst of L≥1 pulses spans L·`HighCycles` + (L−1)·`LowCycles` busy cycles. `done` follows in the next cycle, and IDLE the cycle after that.
- **Zero length:** `burst_len`=0 gives `done` in cycle N and IDLE in N+1. `busy` and `pulse_out` never rise.
- **`pulses_left` updates** in the cycle following the last HIGH cycle of each pulse.
- **Single driver:** `pulse_out` is driven from a dedicated flop and must be glitch-free.

## Test plan
1. **Nominal burst.** `HighCycles`=3, `LowCycles`=2, `burst_len`=3, start edge at 10.
   - `pulse_out`=1 in cycles 10–12, 15–17 and 20–22.
   - `busy` in cycles 10–22; `done` only in cycle 23.
   - `pulses_left` = 3, 2, 1, 0 at cycles 10, 13, 18, 23.
2. **Held start, no retrigger.** Same parameters, `burst_len`=1, `start` held high for cycles 10–40.
   - One pulse in cycles 10–12, `done` at 13, then IDLE with no further pulses.
3. **Abort mid-burst.** Run scenario 1 with `abort`=1 at 16.
   - Cycle 16: `pulse_out`=0, `busy`=0, `pulses_left`=0.
   - `done` never asserts; a new start edge at 25 begins a fresh burst in cycle 25.
4. **Zero length.** `burst_len`=0, start edge at 10.
   - `done`=1 in cycle 10 only; `busy` and `pulse_out` stay 0.
5. **Reset mid-burst.** Run scenario 1 with `reset`=0 at 15 and back to 1 at 16.
   - Cycle 15: all outputs 0.
   - Start low at 18 and high at 20 gives a burst starting in cycle 20 with `pulses_left`=`burst_len`.
6. **Maximum length.** `burst_len`=15, start edge at 10, and `burst_len` changed to 2 at cycle 30.
   - 15 pulses, `busy` in cycles 10–82, `done` at 83.
   - The change to `burst_len` has no effect.
